mem_arbiter: RTL

Round-robin arbiter that shares the single `Simple_Memory_Interface` (4-bit address, 32-bit data, `req`/`ready` handshake) between several requesters, such as the APB slave path and an internal DMA/scrubber port. It sits between the requesters and the memory. It holds a grant until the memory completes the access, and aborts an access with an error if the memory fails to answer within a programmable number of cycles. Arbitration state is fully registered, so no requester can see a grant change mid-access.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter_rr_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// mem_arb_pkg : shared state type and helpers for mem_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = $clog2(MAX_REQ);

  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_arbiter_if : requester-side and memory-side bus of mem_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        req_rnw_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        ready_o;
  logic                      err_o;
  logic [DATA_W-1:0]         rdata_o;
  logic [NUM_REQ-1:0]        grant_o;

  logic                      mem_req_o;
  logic                      mem_rnw_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic                      mem_ready_i;
  logic [DATA_W-1:0]         mem_rdata_i;

  // The arbiter itself
  modport slave (
    input  req_i, req_rnw_i, req_addr_i, req_wdata_i, mem_ready_i, mem_rdata_i,
    output ready_o, err_o, rdata_o, grant_o,
    output mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o
  );

  // The surrounding requesters and memory
  modport master (
    output req_i, req_rnw_i, req_addr_i, req_wdata_i, mem_ready_i, mem_rdata_i,
    input  ready_o, err_o, rdata_o, grant_o,
    input  mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin winner search starting after last_idx
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_idx_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Farthest candidate first, so the nearest one after last_idx overwrites it.
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_i[j] && (j == ((int'(last_idx_i) + k) % NUM_REQ))) begin
          valid_o = 1'b1;
          idx_o   = IDX_W'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter : round-robin arbiter sharing one memory port, with access timeout
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int TMO_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TMO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_I);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_req_masked;
  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_tmo_hit;

  logic               w_sel_req;
  logic               w_sel_rnw;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;

  assign w_grant   = NUM_REQ'(onehot(gnt_q));
  assign w_tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  // The finishing owner is kept out of the search in its last granted cycle.
  assign w_req_masked = bus.req_i & ~((state_q == GRANT) ? w_grant : '0);

  rr_pick #(
    .NUM_REQ    (NUM_REQ)
  ) u_rr_pick (
    .req_i      (w_req_masked),
    .last_idx_i (last_q),
    .valid_o    (w_pick_valid),
    .idx_o      (w_pick_idx)
  );

  always_comb begin
    w_sel_req   = 1'b0;
    w_sel_rnw   = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == IDX_W'(i)) begin
        w_sel_req   = bus.req_i[i];
        w_sel_rnw   = bus.req_rnw_i[i];
        w_sel_addr  = bus.req_addr_i[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    last_d          = last_q;
    tmo_d           = tmo_q;
    bus.ready_o     = '0;
    bus.err_o       = 1'b0;
    bus.rdata_o     = '0;
    bus.grant_o     = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_rnw_o   = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (w_pick_valid) begin
          state_d = GRANT;
          gnt_d   = w_pick_idx;
          tmo_d   = '0;
        end
      end

      GRANT: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_rnw_o   = w_sel_rnw;
        bus.mem_addr_o  = w_sel_addr;
        bus.mem_wdata_o = w_sel_wdata;
        bus.grant_o     = w_grant;

        if (!w_sel_req) begin
          // Owner abandoned the access: release silently.
          state_d = IDLE;
          last_d  = gnt_q;
        end else if (bus.mem_ready_i) begin
          bus.ready_o = w_grant;
          bus.rdata_o = bus.mem_rdata_i;
          state_d     = IDLE;
          last_d      = gnt_q;
        end else if (w_tmo_hit) begin
          bus.ready_o = w_grant;
          bus.err_o   = 1'b1;
          state_d     = IDLE;
          last_d      = gnt_q;
        end else if (tmo_q != TMO_LAST) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire
